// File: rtl/sr_fetch_unit_pkg.sv
// Shared types, defaults and small helpers for the sr_fetch_unit slice.
package sr_fetch_unit_pkg;

  localparam int          FETCH_DEPTH_DEFAULT = 4;
  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;

  typedef logic [31:0] pc_t;
  typedef logic [29:0] word_addr_t;

  // One buffered instruction: the word together with the byte PC it came from.
  typedef struct packed {
    pc_t         pc;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic word_addr_t word_addr(input pc_t pc);
    return pc[31:2];
  endfunction

  function automatic pc_t align_pc(input pc_t pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sr_fetch_unit_if.sv
// Redirect, downstream instruction and instruction-memory signals of the fetch unit.
interface sr_fetch_unit_if;
  import sr_fetch_unit_pkg::*;

  logic       redirect;
  pc_t        redirect_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic [31:0] instr;
  pc_t        instr_pc;
  logic       mem_req;
  word_addr_t mem_addr;
  logic       mem_gnt;
  logic       mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  redirect, redirect_pc, instr_ready, mem_gnt, mem_rvalid, mem_rdata,
    output instr_valid, instr, instr_pc, mem_req, mem_addr
  );

  modport slave (
    output redirect, redirect_pc, instr_ready, mem_gnt, mem_rvalid, mem_rdata,
    input  instr_valid, instr, instr_pc, mem_req, mem_addr
  );

endinterface

// File: rtl/sr_fetch_unit_sync_fifo.sv
// Synchronous FIFO with flush; push while full is accepted only together with a pop.
module sr_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset; occupancy tracking decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/sr_fetch_unit.sv
// Sequential instruction fetch with credit-limited memory requests, PC tagging and redirect flush.
module sr_fetch_unit
  import sr_fetch_unit_pkg::*;
#(
  parameter int  DEPTH    = FETCH_DEPTH_DEFAULT,
  parameter pc_t RESET_PC = RESET_PC_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  sr_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  pc_t          fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] tag_count;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          tag_full, tag_empty, fifo_full, fifo_empty;
  logic          grant, resp, fifo_push, fifo_pop;
  pc_t           tag_head;
  fetch_entry_t  fifo_wdata, fifo_head;

  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign bus.mem_req  = rst_n && !bus.redirect && (credit_used < (CW+1)'(DEPTH));
  assign bus.mem_addr = word_addr(fetch_pc);

  assign grant     = bus.mem_req && bus.mem_gnt;
  assign resp      = bus.mem_rvalid && (outstanding != '0);
  assign fifo_push = resp && (drop_cnt == '0) && !bus.redirect;
  assign fifo_pop  = !fifo_empty && bus.instr_ready && !bus.redirect;

  assign fifo_wdata = '{pc: tag_head, word: bus.mem_rdata};

  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = fifo_empty ? 32'h0 : fifo_head.word;
  assign bus.instr_pc    = fifo_empty ? 32'h0 : fifo_head.pc;

  // Requests still owed by memory after this cycle's grant and response.
  always_comb begin
    outstanding_next = outstanding + CW'(grant) - CW'(resp);
  end

  // Fetch PC, in-flight count and the number of stale responses still to discard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= align_pc(RESET_PC);
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (bus.redirect) begin
        fetch_pc <= align_pc(bus.redirect_pc);
        drop_cnt <= outstanding_next;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  sr_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .push  (grant),
    .pop   (resp),
    .wdata (fetch_pc),
    .rdata (tag_head),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  sr_sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_instr_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.redirect),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.mem_rvalid && (outstanding == '0)));
  a_tag_tracks_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    tag_count == outstanding);
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(grant && tag_full));
  a_tag_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(resp && tag_empty));
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_sr_fetch_unit.sv
// Randomized scoreboard bench for sr_fetch_unit with an in-order variable-latency memory model.
module tb_sr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FILL     = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sr_fetch_unit_if bus ();

  sr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors    = 0;
  int checks    = 0;
  int cyc       = 0;
  int grants    = 0;
  int delivered = 0;
  int gnt_pct   = 100;
  int lat_min   = 1;
  int lat_max   = 1;
  int gnt_limit = 1 << 30;

  logic [31:0] exp_q [$];
  logic [31:0] issue_pc;
  logic [29:0] resp_addr [$];
  int          resp_due [$];

  // Contents of instruction memory: any fixed scrambling of the word address.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // After a reset or redirect the only legal output stream is start, start+4, ...
  function automatic void refill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < FILL; i++) exp_q.push_back(start + 32'(4 * i));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rdr, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    bus.instr_ready = rdy;
    bus.redirect    = rdr;
    bus.redirect_pc = rpc;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.redirect = 1'b0;
    @(negedge clk);
    checkOutput("reset_mem_req", 64'(bus.mem_req), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic runUntil(input int target, input int rdy_pct, input string name);
    int c;
    c = 0;
    while (delivered < target && c < 3000) begin
      applyStimulus(logic'($urandom_range(99) < rdy_pct), 1'b0, 32'h0);
      c++;
    end
    checkOutput(name, 64'(delivered), 64'(target));
  endtask

  // Cycle counter used to schedule memory responses.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: drives gnt randomly and returns queued responses in order.
  initial begin
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (resp_due.size() != 0 && resp_due[0] <= cyc) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem_word(resp_addr[0]);
        void'(resp_due.pop_front());
        void'(resp_addr.pop_front());
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
      end
      bus.mem_gnt = (grants < gnt_limit) && ($urandom_range(99) < gnt_pct);
    end
  end

  // Monitor: tracks the expected fetch address, records grants, scores deliveries.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      resp_addr.delete();
      resp_due.delete();
      issue_pc = RESET_PC;
      refill(RESET_PC);
    end else begin
      if (bus.redirect) begin
        issue_pc = {bus.redirect_pc[31:2], 2'b00};
        refill(issue_pc);
      end
      if (bus.mem_req && bus.mem_gnt) begin
        checkOutput("grant_addr", 64'(bus.mem_addr), 64'(issue_pc[31:2]));
        resp_addr.push_back(bus.mem_addr);
        resp_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        issue_pc = issue_pc + 32'd4;
        grants++;
      end
      if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_extra: got pc 0x%0h, expected no instruction", bus.instr_pc);
        end else begin
          logic [31:0] exp_pc;
          exp_pc = exp_q.pop_front();
          checkOutput("instr_pc", 64'(bus.instr_pc), 64'(exp_pc));
          checkOutput("instr", 64'(bus.instr), 64'(mem_word(exp_pc[31:2])));
        end
        delivered++;
      end
    end
  end

  // Directed scenarios followed by random traffic.
  initial begin
    int g0;
    int d0;
    int c;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b1;

    // Streaming with single-cycle memory: first instruction three cycles after release.
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    doReset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("reset_instr", 64'(bus.instr), 64'd0);
        checkOutput("reset_instr_pc", 64'(bus.instr_pc), 64'd0);
        checkOutput("t1_first_req", 64'(bus.mem_req), 64'd1);
        checkOutput("t1_first_addr", 64'(bus.mem_addr), 64'(RESET_PC[31:2]));
      end
      checkOutput($sformatf("t1_valid_c%0d", k), 64'(bus.instr_valid), 64'(k >= 3));
    end

    // Stalled consumer: credits run out after DEPTH grants.
    applyStimulus(1'b0, 1'b0, 32'h0);
    doReset();
    g0 = grants;
    d0 = delivered;
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t2_grants", 64'(grants - g0), 64'(DEPTH));
    checkOutput("t2_req_full", 64'(bus.mem_req), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t2_req_pop_cycle", 64'(bus.mem_req), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t2_req_after_pop", 64'(bus.mem_req), 64'd1);
    runUntil(d0 + 4, 100, "t2_delivered");

    // Random grant, latency and backpressure.
    gnt_pct = 60; lat_min = 1; lat_max = 5;
    runUntil(delivered + 200, 70, "t3_delivered");

    // Redirect with three slow requests in flight.
    gnt_pct = 100; lat_min = 10; lat_max = 10;
    doReset();
    g0 = grants;
    gnt_limit = grants + 3;
    c = 0;
    while (grants < gnt_limit && c < 20) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      c++;
    end
    checkOutput("t4_inflight", 64'(grants - g0), 64'd3);
    applyStimulus(1'b1, 1'b1, 32'h0000_0100);
    @(negedge clk);
    checkOutput("t4_redirect_req", 64'(bus.mem_req), 64'd0);
    gnt_limit = 1 << 30;
    lat_min = 1; lat_max = 3;
    runUntil(delivered + 8, 100, "t4_delivered");

    // Redirect coinciding with a response and a pop.
    lat_min = 1; lat_max = 1;
    repeat (8) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_2003);
    @(negedge clk);
    checkOutput("t5_rvalid_in_redirect", 64'(bus.mem_rvalid), 64'd1);
    checkOutput("t5_valid_in_redirect", 64'(bus.instr_valid), 64'd1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t5_flushed", 64'(bus.instr_valid), 64'd0);
    runUntil(delivered + 6, 100, "t5_delivered");

    // Reset while the instruction FIFO is full.
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t6_full_valid", 64'(bus.instr_valid), 64'd1);
    checkOutput("t6_full_req", 64'(bus.mem_req), 64'd0);
    doReset();
    @(negedge clk);
    checkOutput("t6_valid_after_reset", 64'(bus.instr_valid), 64'd0);
    checkOutput("t6_req_after_reset", 64'(bus.mem_req), 64'd1);
    checkOutput("t6_addr_after_reset", 64'(bus.mem_addr), 64'(RESET_PC[31:2]));
    runUntil(delivered + 6, 100, "t6_delivered");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound in case a scenario stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
